neuron_mac_seq: RTL and testbench
=================================

Name: neuron_mac_seq

Overview:
- Parametrised successor to the single-product neuron accumulator.
- Computes one neuron output from N_INPUTS serially streamed (x, weight) pairs: full-precision multiply-accumulate, one-time bias add, round-half-up, saturation and optional ReLU.
- Valid/ready handshakes on the input and output sides, so it can be chained or fed from a weight/activation FIFO inside the neuron layer.

Parameters:
- DATA_W, 8: width of x, weight, bias and y; signed two's complement.
- FRAC_W, 4: fractional bits of x, weight, bias and y. Must be ≥1 and <DATA_W.
- N_INPUTS, 4: beats (products) per neuron evaluation. Must be ≥1.
- RELU_EN, 1: 1 clamps negative results to 0; 0 passes signed result.
- Derived localparam ACC_W = 2*DATA_W + $clog2(N_INPUTS) + 1. Not user-settable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort: drop partial sum and return to IDLE.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_x  in  DATA_W  activation, Q(DATA_W-FRAC_W).FRAC_W.
- in_w  in  DATA_W  weight, same Q format.
- bias  in  DATA_W  bias, same Q format; sampled on the first beat of an evaluation.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_y  out  DATA_W  result, same Q format.
- out_sat  out  1  result was saturated; qualified by out_valid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; accumulator, beat counter and bias register = 0.
  - out_valid=0, out_y=0, out_sat=0, in_ready=1.
  - Reset mid-evaluation discards everything; no output is produced.
- States: IDLE, ACCUM, FINISH, OUT.
- IDLE:
  - in_ready=1.
  - Beat accepted (in_valid&&in_ready): acc <= sext(x*w), bias_q <= bias, cnt <= 1.
  - Next state: FINISH if N_INPUTS==1, else ACCUM.
- ACCUM:
  - in_ready=1.
  - Each accepted beat: acc <= acc + sext(x*w), cnt++.
  - The beat making cnt==N_INPUTS moves to FINISH.
  - Cycles with in_valid=0 hold state (bubbles allowed).
- FINISH (exactly one cycle, in_ready=0):
  - s = acc + (sext(bias_q) << FRAC_W). Products are Q.2F, so bias is aligned by FRAC_W.
  - r = (s + (1 << (FRAC_W-1))) >>> FRAC_W. This is round-half-up toward +inf; the shift is arithmetic.
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; out_sat=1 if clipped.
  - If RELU_EN and r<0: out_y=0, out_sat=0.
  - Register out_y/out_sat, set out_valid=1, go to OUT.
- OUT:
  - in_ready=0; out_valid=1; out_y/out_sat held stable until out_valid&&out_ready.
  - On handshake: out_valid=0 next cycle, return to IDLE.
  - No input/output overlap; the next evaluation's first beat is accepted in IDLE.
- Latency: last beat accepted at edge E → out_valid high after edge E+1 (FINISH registers the result). Minimum throughput is N_INPUTS+2 cycles per result with out_ready=1.
- clear=1:
  - In IDLE/ACCUM/FINISH: return to IDLE, zero acc/cnt, no output.
  - In OUT: ignored; a produced result is never dropped.
  - clear has priority over a simultaneous input beat, which is not accepted: in_ready is forced 0 while clear=1.
- Width rules: ACC_W guarantees no internal overflow for any N_INPUTS beats plus bias and rounding constant. Saturation happens only at the output.
- bias is ignored except on the first accepted beat.

Decomposition:
- Package neuron_pkg:
  - state enum type (IDLE, ACCUM, FINISH, OUT).
  - function sat_signed(value, width) returning clipped value and flag.
  - rounding-constant helper.
- Sub-module fxp_round_sat: purely combinational align-bias/round/saturate/ReLU stage. It is instantiated once from FINISH logic and is reusable by later layer blocks.

Test Plan (DATA_W=8, FRAC_W=4, N_INPUTS=4):
- Basic MAC: 4 beats x=16 (1.0), w=16 (1.0), bias=8 (0.5), RELU_EN=1 → out_y=72 (4.5), out_sat=0. out_valid rises 2 edges after the last beat.
- Rounding: beat0 x=1, w=8, others x=0, bias=0 → s=8, out_y=1. Repeat with w=-8 → out_y=0 (RELU_EN=0, half rounds up to 0).
- Saturation/ReLU:
  - x=16, w=32 ×4, bias=16 → 9.0 clips to out_y=127, out_sat=1.
  - x=-16, w=16 ×4, bias=0 → out_y=0 (RELU_EN=1) or 0xC0=-64 (RELU_EN=0), out_sat=0.
  - x=-128, w=127 ×4 with RELU_EN=0 → out_y=-128, out_sat=1.
- Handshake: in_valid toggles with bubbles between beats → same result as basic case. out_ready low 5 cycles → out_y stable, in_ready=0 throughout, then one transfer.
- Abort/reset:
  - clear after 2 beats → busy=0 next cycle, no out_valid; a fresh 4-beat evaluation gives correct result.
  - rst asserted mid-ACCUM → all outputs 0 immediately (asynchronous); after release the next evaluation is correct.
- Back-to-back: 3 consecutive evaluations with out_ready=1 → one result per 6 cycles, each independent (no accumulator carry-over).

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and fixed-point helpers for the neuron datapath blocks.
// Wide intermediates are 64 bits, so every legal accumulator width fits with headroom.
package neuron_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, FINISH, OUT} state_t;

    localparam int WIDE_W = 64;
    localparam logic signed [WIDE_W-1:0] ONE_W = WIDE_W'(1);

    typedef struct packed {
        logic signed [WIDE_W-1:0] val;
        logic                     sat;
    } sat_res_t;

    // Clip a wide signed value into the signed range of 'width' bits.
    function automatic sat_res_t sat_signed(input logic signed [WIDE_W-1:0] value,
                                            input int width);
        sat_res_t res;
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi = (ONE_W <<< (width - 1)) - ONE_W;
        lo = -hi - ONE_W;
        res.val = value;
        res.sat = 1'b0;
        if (value > hi) begin
            res.val = hi;
            res.sat = 1'b1;
        end else if (value < lo) begin
            res.val = lo;
            res.sat = 1'b1;
        end
        return res;
    endfunction

    function automatic logic signed [WIDE_W-1:0] round_const(input int frac_w);
        return ONE_W <<< (frac_w - 1);
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational output stage: add aligned bias, round half up, saturate, optional ReLU.
// Accumulator is Q.2F; the bias is Q.F so it is shifted up by FRAC_W before the add.
module fxp_round_sat
    import neuron_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int FRAC_W  = 4,
    parameter int ACC_W   = 19,
    parameter int RELU_EN = 1
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [DATA_W-1:0] bias,
    output logic signed [DATA_W-1:0] y,
    output logic                     sat
);

    logic signed [WIDE_W-1:0] acc_w;
    logic signed [WIDE_W-1:0] bias_w;
    logic signed [WIDE_W-1:0] s;
    logic signed [WIDE_W-1:0] r;
    sat_res_t                 clip;
    logic                     unused_hi;

    always_comb begin
        acc_w  = WIDE_W'(acc);
        bias_w = WIDE_W'(bias) <<< FRAC_W;
        s      = acc_w + bias_w;
        // Arithmetic shift floors, so adding half first rounds ties toward +inf.
        r      = (s + round_const(FRAC_W)) >>> FRAC_W;
        clip   = sat_signed(r, DATA_W);
        y      = clip.val[DATA_W-1:0];
        sat    = clip.sat;
        if (RELU_EN != 0 && r < 0) begin
            y   = '0;
            sat = 1'b0;
        end
    end

    assign unused_hi = ^clip.val[WIDE_W-1:DATA_W];

endmodule

// File: rtl/neuron_mac_seq.sv
// Serial neuron: N_INPUTS (x, w) beats are multiply-accumulated at full precision,
// then one FINISH cycle applies bias/round/saturate/ReLU and holds the result for downstream.
module neuron_mac_seq
    import neuron_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int FRAC_W   = 4,
    parameter int N_INPUTS = 4,
    parameter int RELU_EN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_w,
    input  logic [DATA_W-1:0] bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic              out_sat,
    output logic              busy
);

    localparam int ACC_W = 2 * DATA_W + $clog2(N_INPUTS) + 1;
    localparam int CNT_W = $clog2(N_INPUTS + 1);

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [DATA_W-1:0]  bias_q, bias_d;
    logic [DATA_W-1:0]         out_y_q, out_y_d;
    logic                      out_sat_q, out_sat_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [DATA_W-1:0]   fin_y;
    logic                       fin_sat;
    logic                       take;

    assign prod     = $signed(in_x) * $signed(in_w);
    assign prod_ext = ACC_W'(prod);

    fxp_round_sat #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W),
        .RELU_EN(RELU_EN)
    ) u_round (
        .acc (acc_q),
        .bias(bias_q),
        .y   (fin_y),
        .sat (fin_sat)
    );

    // clear wins over a simultaneous beat, so the beat must not be acknowledged.
    assign in_ready  = (state_q == IDLE || state_q == ACCUM) && !clear;
    assign take      = in_valid && in_ready;
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign out_y     = out_y_q;
    assign out_sat   = out_sat_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        bias_d    = bias_q;
        out_y_d   = out_y_q;
        out_sat_d = out_sat_q;
        case (state_q)
            IDLE, ACCUM, FINISH: begin
                if (clear) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (state_q == FINISH) begin
                    out_y_d   = fin_y;
                    out_sat_d = fin_sat;
                    state_d   = OUT;
                end else if (take) begin
                    if (state_q == IDLE) begin
                        acc_d  = prod_ext;
                        bias_d = $signed(bias);
                        cnt_d  = CNT_W'(1);
                    end else begin
                        acc_d = acc_q + prod_ext;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_d == CNT_W'(N_INPUTS)) state_d = FINISH;
                    else                           state_d = ACCUM;
                end
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            bias_q    <= '0;
            out_y_q   <= '0;
            out_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            bias_q    <= bias_d;
            out_y_q   <= out_y_d;
            out_sat_q <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed + randomized bench: a ReLU and a linear instance share one input stream
// and are compared against an integer-arithmetic reference of the neuron equation.
module tb_neuron_mac_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_x;
    logic [7:0] in_w;
    logic [7:0] bias;
    logic       out_ready;

    logic       in_ready_r, out_valid_r, sat_r, busy_r;
    logic       in_ready_l, out_valid_l, sat_l, busy_l;
    logic [7:0] y_r, y_l;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int xs[4];
    int ws[4];
    int bv;
    int t_start;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neuron_mac_seq #(.DATA_W(8), .FRAC_W(4), .N_INPUTS(4), .RELU_EN(1)) u_relu (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_r),
        .in_x(in_x), .in_w(in_w), .bias(bias), .out_valid(out_valid_r),
        .out_ready(out_ready), .out_y(y_r), .out_sat(sat_r), .busy(busy_r)
    );

    neuron_mac_seq #(.DATA_W(8), .FRAC_W(4), .N_INPUTS(4), .RELU_EN(0)) u_lin (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_x(in_x), .in_w(in_w), .bias(bias), .out_valid(out_valid_l),
        .out_ready(out_ready), .out_y(y_l), .out_sat(sat_l), .busy(busy_l)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Real-valued neuron: sum in units of 2^-8, floor((sum + half) / 16), clip, ReLU.
    task automatic model(input bit relu, output int y, output int s);
        int sum, num, r;
        sum = bv * 16;
        for (int i = 0; i < 4; i++) sum += xs[i] * ws[i];
        num = sum + 8;
        if (num >= 0) r = num / 16;
        else          r = -((-num + 15) / 16);
        s = 0;
        if (r > 127)  begin r = 127;  s = 1; end
        if (r < -128) begin r = -128; s = 1; end
        if (relu && r < 0) begin r = 0; s = 0; end
        y = r;
    endtask

    task automatic set_all(input int x, input int w, input int b);
        for (int i = 0; i < 4; i++) begin xs[i] = x; ws[i] = w; end
        bv = b;
    endtask

    task automatic send_beat(input int i);
        in_valid = 1'b1;
        in_x     = 8'(xs[i]);
        in_w     = 8'(ws[i]);
        bias     = (i == 0) ? 8'(bv) : 8'($urandom);
        @(negedge clk);
    endtask

    task automatic eval(input string tag, input int bub_max, input int hold, input bit clr_out);
        int ey_r, es_r, ey_l, es_l, yr0, yl0;
        for (int i = 0; i < 4; i++) begin
            int nb;
            nb = (bub_max > 0) ? int'($urandom_range(bub_max, 1)) : 0;
            for (int k = 0; k < nb; k++) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            send_beat(i);
            if (i == 0) t_start = cyc;
        end
        in_valid  = 1'b0;
        out_ready = (hold == 0);
        model(1'b1, ey_r, es_r);
        model(1'b0, ey_l, es_l);
        chk({tag, ".valid_early"}, int'(out_valid_r), 0);
        @(negedge clk);
        chk({tag, ".valid_rise"}, int'(out_valid_r), 1);
        chk({tag, ".y_relu"}, int'($signed(y_r)), ey_r);
        chk({tag, ".sat_relu"}, int'(sat_r), es_r);
        chk({tag, ".valid_lin"}, int'(out_valid_l), 1);
        chk({tag, ".y_lin"}, int'($signed(y_l)), ey_l);
        chk({tag, ".sat_lin"}, int'(sat_l), es_l);
        chk({tag, ".in_ready_out"}, int'(in_ready_r), 0);
        yr0 = int'($signed(y_r));
        yl0 = int'($signed(y_l));
        for (int h = 0; h < hold; h++) begin
            clear = clr_out && (h == 0);
            @(negedge clk);
            clear = 1'b0;
            chk({tag, ".hold_valid"}, int'(out_valid_r), 1);
            chk({tag, ".hold_y_relu"}, int'($signed(y_r)), yr0);
            chk({tag, ".hold_y_lin"}, int'($signed(y_l)), yl0);
            chk({tag, ".hold_in_ready"}, int'(in_ready_l), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".valid_drop"}, int'(out_valid_r), 0);
        chk({tag, ".busy_drop"}, int'(busy_l), 0);
        chk({tag, ".in_ready_idle"}, int'(in_ready_r), 1);
    endtask

    initial begin
        int t1, t2;
        rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
        in_x = '0; in_w = '0; bias = '0; out_ready = 1'b0;
        #1;
        chk("rst.in_ready", int'(in_ready_r), 1);
        chk("rst.out_valid", int'(out_valid_r), 0);
        chk("rst.out_y", int'(y_l), 0);
        chk("rst.out_sat", int'(sat_l), 0);
        chk("rst.busy", int'(busy_r), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        set_all(16, 16, 8);    eval("basic", 0, 0, 1'b0);
        set_all(16, 16, 8);    eval("bubbles", 3, 0, 1'b0);
        set_all(16, 16, 8);    eval("stall5", 0, 5, 1'b1);

        set_all(0, 5, 0); xs[0] = 1; ws[0] = 8;   eval("round_up", 0, 0, 1'b0);
        set_all(0, 5, 0); xs[0] = 1; ws[0] = -8;  eval("round_tie_neg", 0, 0, 1'b0);
        set_all(16, 32, 16);   eval("sat_hi", 0, 0, 1'b0);
        set_all(-16, 16, 0);   eval("neg", 0, 0, 1'b0);
        set_all(-128, 127, 0); eval("sat_lo", 0, 0, 1'b0);

        // Abort after two beats with a beat offered in the same cycle as clear.
        set_all(16, 16, 8);
        send_beat(0);
        send_beat(1);
        clear = 1'b1; in_valid = 1'b1;
        #1 chk("clear.in_ready", int'(in_ready_r), 0);
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        chk("clear.busy", int'(busy_r), 0);
        chk("clear.no_valid", int'(out_valid_l), 0);
        @(negedge clk);
        chk("clear.still_idle", int'(out_valid_r), 0);
        set_all(3, -7, -20);   eval("after_clear", 0, 0, 1'b0);

        // Asynchronous reset mid-accumulation; previous linear result was nonzero.
        set_all(16, 16, 8);    eval("pre_rst", 0, 0, 1'b0);
        send_beat(0);
        send_beat(1);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst.out_y", int'(y_l), 0);
        chk("arst.busy", int'(busy_r), 0);
        chk("arst.out_valid", int'(out_valid_l), 0);
        chk("arst.in_ready", int'(in_ready_r), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        set_all(-5, 9, 33);    eval("after_rst", 0, 0, 1'b0);

        // Back-to-back with out_ready high: one result every N_INPUTS+2 cycles.
        set_all(16, 16, 8);    eval("b2b0", 0, 0, 1'b0); t1 = t_start;
        set_all(-16, 16, 0);   eval("b2b1", 0, 0, 1'b0); t2 = t_start;
        chk("b2b.period01", t2 - t1, 6);
        t1 = t2;
        set_all(16, 32, 16);   eval("b2b2", 0, 0, 1'b0); t2 = t_start;
        chk("b2b.period12", t2 - t1, 6);

        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 4; i++) begin
                xs[i] = int'($signed(8'($urandom)));
                ws[i] = int'($signed(8'($urandom)));
            end
            bv = int'($signed(8'($urandom)));
            eval("rand", int'($urandom_range(2)), int'($urandom_range(3)), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
